// File: rtl/read_response_router.sv
// read_response_router
//   Routes slave read-data channels back to a single master in the order the
//   address router accepted the bursts. Each accepted address pushes
//   {slave, len} into an in-order queue; the head entry selects which slave's
//   R channel is forwarded. A head whose slave index is out of range produces
//   len+1 locally generated DECERR beats.
//
//   Optional feature (macro RR_LAST_CHECK_EN): m_rlast is derived from the
//   beat counter instead of the slave, and protocol_err flags (sticky) any
//   accepted beat whose s_rlast disagrees with the beat count. Without the
//   macro m_rlast follows the slave and protocol_err is tied low.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   a_push/a_slave/a_len  : address handshake completed, its slave and len-1
//   a_ready               : queue not full; gate the address valid with it
//   s_rdata/s_rresp/s_rlast/s_rvalid/s_rready : per-slave R channels
//   m_rdata/m_rresp/m_rlast/m_rvalid/m_rready : master R channel
//   protocol_err          : sticky burst-length mismatch flag
module read_response_router #(
  parameter int num_slaves      = 5,
  parameter int max_outstanding = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         a_push,
  input  logic [2:0]                   a_slave,
  input  logic [7:0]                   a_len,
  output logic                         a_ready,
  input  logic [num_slaves-1:0][31:0]  s_rdata,
  input  logic [num_slaves-1:0][1:0]   s_rresp,
  input  logic [num_slaves-1:0]        s_rlast,
  input  logic [num_slaves-1:0]        s_rvalid,
  output logic [num_slaves-1:0]        s_rready,
  output logic [31:0]                  m_rdata,
  output logic [1:0]                   m_rresp,
  output logic                         m_rlast,
  output logic                         m_rvalid,
  input  logic                         m_rready,
  output logic                         protocol_err
);

  localparam int PW = $clog2(max_outstanding);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(max_outstanding);
  localparam logic [3:0]    NS   = 4'(num_slaves);

  logic [2:0]    q_slave [max_outstanding];
  logic [7:0]    q_len   [max_outstanding];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    beat;

  logic [2:0]    head_slave;
  logic [7:0]    head_len;
  logic          not_empty, dec_err, last_cnt;
  logic          push, pop, beat_fire;

  logic [num_slaves-1:0] sel_hot;
  logic [31:0]           sel_rdata;
  logic [1:0]            sel_rresp;
  logic                  sel_rlast, sel_rvalid;

  assign head_slave = q_slave[rd_ptr];
  assign head_len   = q_len[rd_ptr];
  assign not_empty  = (count != '0);
  assign dec_err    = ({1'b0, head_slave} >= NS);
  assign last_cnt   = (beat == head_len);

  // Full means full: a pop in the same cycle does not open a slot.
  assign a_ready   = (count != FULL);
  assign push      = a_push && a_ready;
  assign beat_fire = m_rvalid && m_rready;
  assign pop       = beat_fire && m_rlast;

  // Mux the head slave's channel; comparing against each index keeps the
  // select in range for any num_slaves.
  always_comb begin
    sel_hot    = '0;
    sel_rdata  = '0;
    sel_rresp  = '0;
    sel_rlast  = 1'b0;
    sel_rvalid = 1'b0;
    for (int i = 0; i < num_slaves; i++) begin
      if (head_slave == 3'(i)) begin
        sel_hot[i] = 1'b1;
        sel_rdata  = s_rdata[i];
        sel_rresp  = s_rresp[i];
        sel_rlast  = s_rlast[i];
        sel_rvalid = s_rvalid[i];
      end
    end
  end

  always_comb begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_rresp  = '0;
    m_rlast  = 1'b0;
    s_rready = '0;
    if (not_empty) begin
      if (dec_err) begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
        m_rlast  = last_cnt;
      end else begin
        m_rvalid = sel_rvalid;
        m_rdata  = sel_rdata;
        m_rresp  = sel_rresp;
`ifdef RR_LAST_CHECK_EN
        m_rlast  = last_cnt;
`else
        m_rlast  = sel_rlast;
`endif
        s_rready = sel_hot & {num_slaves{m_rready}};
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_slave[wr_ptr] <= a_slave;
      q_len[wr_ptr]   <= a_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      beat   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop)            beat <= '0;
      else if (beat_fire) beat <= beat + 8'd1;
    end
  end

`ifdef RR_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      protocol_err <= 1'b0;
    else if (beat_fire && !dec_err && (sel_rlast != last_cnt))
      protocol_err <= 1'b1;
  end
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_read_response_router.sv
module tb_read_response_router;
  localparam int NS = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 a_push;
  logic [2:0]           a_slave;
  logic [7:0]           a_len;
  logic                 a_ready;
  logic [NS-1:0][31:0]  s_rdata;
  logic [NS-1:0][1:0]   s_rresp;
  logic [NS-1:0]        s_rlast, s_rvalid, s_rready;
  logic [31:0]          m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast, m_rvalid, m_rready;
  logic                 protocol_err;

  int total = 0;
  int bad   = 0;

  read_response_router #(.num_slaves(NS), .max_outstanding(4)) dut (
    .clk(clk), .reset(reset),
    .a_push(a_push), .a_slave(a_slave), .a_len(a_len), .a_ready(a_ready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; checks follow #1 later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; a_push = 1'b0; a_slave = '0; a_len = '0;
    s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rvalid = '0; m_rready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_a_ready", 32'(a_ready), 1);
    chk("rst_m_rvalid", 32'(m_rvalid), 0);
    chk("rst_s_rready", 32'(s_rready), 0);
    chk("rst_perr", 32'(protocol_err), 0);

    // ---- single burst: slave 2, len 3 ----
    a_push = 1'b1; a_slave = 3'd2; a_len = 8'd3;
    s_rvalid = 5'b00100; s_rdata[2] = 32'hA0;
    #1 chk("b1_no_bypass", 32'(m_rvalid), 0);
    tick();
    a_push = 1'b0;
    #1 chk("b1_stall_rvalid", 32'(m_rvalid), 1);
    chk("b1_stall_rready", 32'(s_rready), 0);
    tick();
    m_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_rdata[2] = 32'hA0 + 32'(b);
      s_rresp[2] = 2'(b);
      s_rlast[2] = (b == 3);
      #1;
      chk("b1_rdata", m_rdata, 32'hA0 + 32'(b));
      chk("b1_rresp", 32'(m_rresp), 32'(b));
      chk("b1_rlast", 32'(m_rlast), (b == 3) ? 1 : 0);
      chk("b1_s_rready", 32'(s_rready), 32'b00100);
      tick();
    end
    s_rvalid = '0; s_rlast = '0; s_rresp = '0; m_rready = 1'b0;
    #1 chk("b1_empty_rvalid", 32'(m_rvalid), 0);
    chk("b1_empty_a_ready", 32'(a_ready), 1);

    // ---- four back-to-back pushes 1,3,0,4 len 0 ----
    a_len = 8'd0;
    a_push = 1'b1; a_slave = 3'd1; #1 chk("fill_rdy0", 32'(a_ready), 1); tick();
    a_slave = 3'd3; #1 chk("fill_rdy1", 32'(a_ready), 1); tick();
    a_slave = 3'd0; #1 chk("fill_rdy2", 32'(a_ready), 1); tick();
    a_slave = 3'd4; #1 chk("fill_rdy3", 32'(a_ready), 1); tick();
    a_push = 1'b0;
    #1 chk("fill_full", 32'(a_ready), 0);
    for (int i = 0; i < NS; i++) begin
      s_rdata[i] = 32'h10 + 32'(i);
      s_rresp[i] = 2'(i);
    end
    s_rvalid = 5'b11111; s_rlast = 5'b11111;
    #1 chk("hold_rdata", m_rdata, 32'h11);
    chk("hold_s_rready", 32'(s_rready), 0);
    // pop slave 1 while trying to push: push must be refused
    m_rready = 1'b1; a_push = 1'b1; a_slave = 3'd2;
    #1 chk("pp_a_ready", 32'(a_ready), 0);
    chk("pp_s_rready", 32'(s_rready), 32'b00010);
    chk("pp_rdata", m_rdata, 32'h11);
    tick();
    m_rready = 1'b0;
    #1 chk("pp_after_ready", 32'(a_ready), 1);
    chk("pp_head3", m_rdata, 32'h13);
    tick();
    a_push = 1'b0;
    #1 chk("pp_refull", 32'(a_ready), 0);
    m_rready = 1'b1;
    begin
      int exp_s[4] = '{3, 0, 4, 2};
      for (int k = 0; k < 4; k++) begin
        #1;
        chk("drain_rdata", m_rdata, 32'h10 + 32'(exp_s[k]));
        chk("drain_rresp", 32'(m_rresp), 32'(exp_s[k] % 4));
        chk("drain_s_rready", 32'(s_rready), 32'(1 << exp_s[k]));
        chk("drain_rlast", 32'(m_rlast), 1);
        tick();
      end
    end
    #1 chk("drain_empty", 32'(m_rvalid), 0);
    chk("drain_s_rready0", 32'(s_rready), 0);

    // ---- decode error: slave 6 len 1 ----
    m_rready = 1'b0;
    a_push = 1'b1; a_slave = 3'd6; a_len = 8'd1;
    tick();
    a_push = 1'b0; m_rready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("de_rvalid", 32'(m_rvalid), 1);
      chk("de_rdata", m_rdata, 0);
      chk("de_rresp", 32'(m_rresp), 3);
      chk("de_rlast", 32'(m_rlast), (b == 1) ? 1 : 0);
      chk("de_s_rready", 32'(s_rready), 0);
      tick();
    end
    #1 chk("de_empty", 32'(m_rvalid), 0);

    // ---- early rlast from slave 0 on a len-1 burst ----
    m_rready = 1'b0; s_rvalid = 5'b00001; s_rlast = 5'b00001;
    a_push = 1'b1; a_slave = 3'd0; a_len = 8'd1;
    tick();
    a_push = 1'b0; m_rready = 1'b1;
`ifdef RR_LAST_CHECK_EN
    #1 chk("lc_b0_rlast", 32'(m_rlast), 0);
    tick();
    s_rlast = 5'b00000;
    #1 chk("lc_perr_set", 32'(protocol_err), 1);
    chk("lc_b1_rlast", 32'(m_rlast), 1);
    tick();
    #1 chk("lc_perr_sticky", 32'(protocol_err), 1);
    chk("lc_empty", 32'(m_rvalid), 0);
`else
    #1 chk("lc_b0_rlast", 32'(m_rlast), 1);
    tick();
    #1 chk("lc_perr_tied", 32'(protocol_err), 0);
    chk("lc_empty", 32'(m_rvalid), 0);
`endif

    // ---- reset mid-burst with two entries queued ----
    m_rready = 1'b0; s_rvalid = 5'b11111; s_rlast = '0;
    a_push = 1'b1; a_slave = 3'd2; a_len = 8'd3; tick();
    a_slave = 3'd1; a_len = 8'd0; tick();
    a_push = 1'b0; m_rready = 1'b1;
    #1 chk("mr_beat0", m_rdata, 32'h12);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_rvalid", 32'(m_rvalid), 0);
    chk("mr_a_ready", 32'(a_ready), 1);
    chk("mr_s_rready", 32'(s_rready), 0);
    chk("mr_perr", 32'(protocol_err), 0);
    reset = 1'b0;
    #1 chk("mr_rvalid_post", 32'(m_rvalid), 0);
    // beat counter must restart at 0: len-0 decode error is last on beat 0
    a_push = 1'b1; a_slave = 3'd7; a_len = 8'd0;
    tick();
    a_push = 1'b0;
    #1 chk("mr_de_rlast", 32'(m_rlast), 1);
    chk("mr_de_rresp", 32'(m_rresp), 3);
    tick();
    #1 chk("mr_final_empty", 32'(m_rvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
